// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// the captured-request record and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_meta_t;

  // Unsigned variants only exist for loads, so BU/HU encodings are illegal stores.
  function automatic logic req_misaligned(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = lane[0];
      F3_W:    err = (lane != 2'b00);
      F3_BU:   err = write;
      F3_HU:   err = write | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and word-memory port bundle for the load/store unit.
// slave is the unit's view; master is the core + memory environment's view.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_misaligned;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic                  mem_write_enable;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte/half extraction with sign/zero extension for loads,
// and byte/half merge into the fetched word for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];

    load_result = '0;
    case (funct3)
      F3_B:    load_result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_result = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_result = word;
      F3_BU:   load_result = {24'h0, byte_sel};
      F3_HU:   load_result = {16'h0, half_sel};
      default: load_result = '0;
    endcase

    // Full-word stores bypass the fetched word entirely.
    merged_word = wdata;
    case (funct3)
      F3_B: begin
        merged_word = word;
        merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged_word = word;
        merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store initiator on a word-only memory; latency error 1, load/SW 2,
// SB/SH 3 cycles (read-modify-write); req_ready only in IDLE, response has no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  req_meta_t             meta_q;
  logic                  err_q;
  logic [31:0]           word_q;
  logic [31:0]           result_q;

  logic                  req_err;
  logic [31:0]           lane_word;
  logic [31:0]           load_result;
  logic [31:0]           merged_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  ready_c;
  logic                  rsp_valid_c;
  logic [31:0]           rsp_rdata_c;
  logic                  rsp_mis_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [31:0]           mem_wdata_c;
  logic                  mem_we_c;

  assign req_err   = req_misaligned(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // READ works on the live memory word; WRITE merges into the copy captured in READ.
  assign lane_word = (state_q == READ) ? bus.mem_read_data : word_q;

  lsu_lane_align u_lane_align (
    .word        (lane_word),
    .lane        (addr_q[1:0]),
    .funct3      (meta_q.funct3),
    .wdata       (meta_q.wdata),
    .load_result (load_result),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      meta_q   <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        addr_q        <= bus.req_addr;
        meta_q.write  <= bus.req_write;
        meta_q.funct3 <= bus.req_funct3;
        meta_q.wdata  <= bus.req_wdata;
        err_q         <= req_err;
        result_q      <= '0;
      end
      if (state_q == READ) begin
        word_q <= bus.mem_read_data;
        if (!meta_q.write) result_q <= load_result;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_rdata_c = '0;
    rsp_mis_c   = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          if (req_err)
            state_d = RESP;
          else if (bus.req_write && bus.req_funct3 == F3_W)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        mem_addr_c = word_addr;
        state_d    = meta_q.write ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr_c  = word_addr;
        mem_wdata_c = merged_word;
        mem_we_c    = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = result_q;
        rsp_mis_c   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the outputs must be forced quiet before the edge lands.
    if (!rst_n) begin
      ready_c     = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_rdata_c = '0;
      rsp_mis_c   = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      mem_we_c    = 1'b0;
    end
  end

  assign bus.req_ready        = ready_c;
  assign bus.rsp_valid        = rsp_valid_c;
  assign bus.rsp_rdata        = rsp_rdata_c;
  assign bus.rsp_misaligned   = rsp_mis_c;
  assign bus.mem_address      = mem_addr_c;
  assign bus.mem_write_data   = mem_wdata_c;
  assign bus.mem_write_enable = mem_we_c;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word memory model, expected responses and
// writes queued at accept time and compared when the unit produces them.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(32)) bus();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Word memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b1;
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int unsigned acc;
    int unsigned lat;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned acc;
    int unsigned lat;
  } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  rsp_exp_t re;
  wr_exp_t  we;
  always @(negedge clk) begin
    #1;
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check_val("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        re = rsp_q.pop_front();
        check_val("rsp_rdata", bus.rsp_rdata, re.rdata);
        check_val("rsp_misaligned", {31'd0, bus.rsp_misaligned}, {31'd0, re.mis});
        check_val("rsp_latency", cyc - re.acc + 1, re.lat);
      end
    end
    if (bus.mem_write_enable) begin
      if (wr_q.size() == 0) begin
        check_val("write_unexpected", 32'd1, 32'd0);
      end else begin
        we = wr_q.pop_front();
        check_val("write_addr", bus.mem_address, we.addr);
        check_val("write_data", bus.mem_write_data, we.data);
        check_val("write_cycle", cyc - we.acc + 1, we.lat);
      end
    end
  end

  task automatic wait_idle();
    int waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) check_val("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_mis, input int unsigned lat, input logic exp_wr,
                       input logic [31:0] exp_wdata, input int unsigned wr_lat);
    int unsigned acc;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    wait_idle();
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    rsp_q.push_back('{exp_rdata, exp_mis, acc, lat});
    if (exp_wr) wr_q.push_back('{addr & ~32'h3, exp_wdata, acc, wr_lat});
    @(negedge clk);
    // Fields need only be stable on the accept cycle.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    check_val("mem_address_first", bus.mem_address, exp_mis ? 32'h0 : (addr & ~32'h3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("rst_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
    check_val("rst_mem_address", bus.mem_address, 32'h0);
    check_val("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_val("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    //    wr    f3      addr     wdata         rdata         mis lat wr  wdata        wlat
    issue(1'b0, F3_B,  32'h11, 32'h0,        32'hFFFFFFAA, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_BU, 32'h11, 32'h0,        32'h000000AA, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_H,  32'h12, 32'h0,        32'hFFFF8899, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_HU, 32'h12, 32'h0,        32'h00008899, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_W,  32'h10, 32'h0,        32'h8899AABB, 0,  2,  0,  32'h0,        0);
    issue(1'b1, F3_B,  32'h13, 32'h12345655, 32'h0,        0,  3,  1,  32'h5599AABB, 2);
    issue(1'b1, F3_H,  32'h10, 32'h0000CAFE, 32'h0,        0,  3,  1,  32'h5599CAFE, 2);
    issue(1'b1, F3_W,  32'h20, 32'hDEADBEEF, 32'h0,        0,  2,  1,  32'hDEADBEEF, 1);
    issue(1'b0, F3_W,  32'h20, 32'h0,        32'hDEADBEEF, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_W,  32'h12, 32'h0,        32'h0,        1,  1,  0,  32'h0,        0);
    issue(1'b1, F3_H,  32'h11, 32'hFFFFFFFF, 32'h0,        1,  1,  0,  32'h0,        0);
    issue(1'b0, 3'b011, 32'h10, 32'h0,       32'h0,        1,  1,  0,  32'h0,        0);
    issue(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF, 32'h0,        1,  1,  0,  32'h0,        0);
    issue(1'b0, F3_B,  32'h12, 32'h0,        32'hFFFFFF99, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_BU, 32'h13, 32'h0,        32'h00000055, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_H,  32'h10, 32'h0,        32'hFFFFCAFE, 0,  2,  0,  32'h0,        0);
    issue(1'b0, F3_HU, 32'h10, 32'h0,        32'h0000CAFE, 0,  2,  0,  32'h0,        0);

    // Reset lands on the WRITE cycle of an SB: nothing may be written or answered.
    wait_idle();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h13;
    bus.req_wdata  = 32'h000000EE;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
    check_val("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check_val("rst_hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst_hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst_release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    issue(1'b0, F3_W,  32'h10, 32'h0,        32'h5599CAFE, 0,  2,  0,  32'h0,        0);

    for (int i = 0; i < 50 && (rsp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check_val("rsp_queue_drained", rsp_q.size(), 32'd0);
    check_val("write_queue_drained", wr_q.size(), 32'd0);
    check_val("mem_word_0x10", mem[4], 32'h5599CAFE);
    check_val("mem_word_0x20", mem[8], 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load or store request from the core and turns it into accesses on a word-only memory port.
- The memory port takes a word address and combinational read data, and writes only at word-aligned addresses on a clock edge.
- Byte and halfword loads are handled by lane extraction plus sign or zero extension.
- Byte and halfword stores are handled by read-modify-write.
- Sits between the execute stage and the data memory.

Parameters:
ADDR_WIDTH, 32, width of the request and memory address buses.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE with rst_n high)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
rsp_valid  output  1  one-cycle pulse: request complete
rsp_rdata  output  32  extended load result; 0 for stores and errors
rsp_misaligned  output  1  qualified by rsp_valid: misaligned address or illegal funct3
mem_address  output  ADDR_WIDTH  word-aligned address, bits [1:0] always 00
mem_write_data  output  32  full word to write
mem_write_enable  output  1  write strobe
mem_read_data  input  32  combinational read data for mem_address

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (rst_n low at an edge):
  - state goes to IDLE; captured address, funct3, wdata, word and result registers all go to 0.
  - While rst_n is low: req_ready=0, rsp_valid=0, rsp_misaligned=0, rsp_rdata=0, mem_write_enable=0, mem_address=0.
  - Reset mid-operation abandons the request with no write and no response. mem_write_enable is gated by rst_n.
- IDLE:
  - req_ready=1; mem_address=0; mem_write_enable=0.
  - Accept on req_valid & req_ready and capture all request fields.
  - Error when: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; funct3 in {011,110,111} for loads; funct3 > 010 for stores. Error goes to RESP with rsp_misaligned=1 and no memory access.
  - Otherwise: load goes to READ; SW goes to WRITE; SB/SH go to READ.
- READ:
  - mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Capture mem_read_data at the edge.
  - Load: register the extracted result and go to RESP. SB/SH: go to WRITE.
- Lane rules:
  - lane = addr[1:0].
  - Byte = word[8*lane +: 8]; half = word[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- WRITE:
  - Same mem_address as READ; mem_write_enable=1 for exactly this one cycle.
  - mem_write_data: SW = req_wdata; SB = captured word with lane byte replaced by wdata[7:0]; SH = captured word with the half replaced by wdata[15:0].
  - Next state RESP.
- RESP:
  - rsp_valid=1 for one cycle; no backpressure on the response; next state IDLE.
  - Back-to-back requests: the next request is accepted on the cycle after RESP.
- Latency in cycles after the accept edge, counted to rsp_valid high:
  - error 1
  - load 2
  - SW 2
  - SB/SH 3
- Unaccepted requests are ignored; the request fields need be stable only on the accept cycle.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the lsu_state_t enum {IDLE, READ, WRITE, RESP};
  - the alignment-check function.
- One combinational sub-module, lsu_lane_align, holds load extraction/extension and store merge. Inputs: word, addr[1:0], funct3, wdata. Outputs: load_result, merged_word.

Test Plan:
- Memory word at 0x10 = 0x8899AABB. LB 0x11 -> rsp_rdata 0xFFFFFFAA; LBU 0x11 -> 0x000000AA. rsp_valid 2 cycles after accept; mem_write_enable never asserted.
- LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB, with mem_address=0x10 during READ.
- SB 0x13, wdata 0x12345655 -> one write, on cycle 2, of 0x5599AABB to 0x10; SH 0x10, wdata 0x0000CAFE -> word 0x5599CAFE. rsp_valid on cycle 3, rsp_rdata 0.
- SW 0x20, data 0xDEADBEEF -> write on cycle 1, rsp on cycle 2; a following LW 0x20 returns 0xDEADBEEF.
- LW 0x12, SH 0x11, LB with funct3 3'b011 -> rsp_misaligned=1 on cycle 1, no mem_write_enable, memory unchanged.
- Assert rst_n=0 during the WRITE cycle of SB 0x13 -> no write; state IDLE; req_ready=0 while in reset, then 1 after release; no rsp_valid.
